fft_bin_collector: RTL and testbench
====================================

// Module: fft_bin_collector
// PURPOSE
//  Sink for the FFT pipeline output stream. Each beat carries one pair index plus two complex bins.
//  The block computes an L1 magnitude (|re|+|im|) per bin and stores it in a natural-order bin buffer.
//  Once a frame is complete, it streams the magnitudes out in ascending bin order over a valid/ready
//  interface to the vowel-classifier feature stage.
// PARAMETERS
//  Q_IN    15  MSB index of input data; samples are signed [Q_IN:0]
//  N       8   FFT length in bins, a power of 2 and >= 4
//  ADDR_W  4   width of addr_in; N/2 <= 2**ADDR_W
// PORTS
//  clk          in   1         clock; all logic on the rising edge
//  reset        in   1         asynchronous, active-low reset
//  valid_in     in   1         input beat is valid; there is no backpressure on the input side
//  addr_in      in   ADDR_W    pair index k, in 0..N/2-1
//  data_real_0  in   Q_IN+1    Re X[k], signed
//  data_imag_0  in   Q_IN+1    Im X[k], signed
//  data_real_1  in   Q_IN+1    Re X[k+N/2], signed
//  data_imag_1  in   Q_IN+1    Im X[k+N/2], signed
//  ready_in     in   1         downstream accepts the current output beat
//  valid_out    out  1         output beat is valid
//  bin_out      out  log2(N)   bin index of mag_out
//  mag_out      out  Q_IN+2    unsigned |re|+|im|
//  last_out     out  1         marks the final beat of a frame
//  overflow     out  1         sticky: an input beat was dropped while in DRAIN
//  addr_err     out  1         sticky: an input beat had addr_in >= N/2
// BEHAVIOUR
//  Reset: all outputs are 0, state is COLLECT, the written bitmap is clear and the pair count is 0.
//   Reset is legal mid-frame or mid-drain; the partial frame is discarded.
//  Magnitude:
//   - abs() saturates: -2**Q_IN maps to 2**Q_IN-1.
//   - The sum is zero-extended to Q_IN+2 bits, so it never overflows.
//  COLLECT, on each valid_in beat:
//   - addr_in >= N/2: the beat is ignored and addr_err is set.
//   - Otherwise buf[k] and buf[k+N/2] are written with the magnitudes.
//   - If written[k] was 0, written[k] is set and the count increments.
//   - A duplicate k overwrites buf[k] and buf[k+N/2]; the count is unchanged (last write wins).
//   - When the count reaches N/2, the next state is DRAIN; pairs may arrive in any order.
//  DRAIN:
//   - valid_out rises exactly 1 cycle after the completing beat, with bin_out = 0.
//   - The output register holds bin_out, mag_out and last_out stable while valid_out && !ready_in.
//   - On each valid_out && ready_in, the next bin is presented in the following cycle.
//     This gives zero-bubble streaming while ready_in stays high.
//   - last_out = 1 on the final bin (see CONFIGURATION).
//   - The handshake on the last beat clears the bitmap and the count. The state returns to COLLECT
//     and valid_out drops in that same cycle.
//   - valid_in during DRAIN: the beat is dropped and overflow is set. The buffer is unaffected.
//  The overflow and addr_err flags clear only on reset.
//  The completing beat and the first drain cycle never overlap: that beat's write lands before the
//   first read.
// CONFIGURATION
//  FFT_BIN_HALF_SPECTRUM_EN
//   - Defined: only bins 0..N/2 are streamed, N/2+1 beats, last_out on bin N/2. This is valid for
//     real input by conjugate symmetry.
//   - Undefined: all bins 0..N-1 are streamed, N beats, last_out on bin N-1.
//   - Collection behaviour is identical in both builds.
// STRUCTURE
//  Package fft_pkg holds:
//   - the state enum {COLLECT, DRAIN}
//   - localparams BIN_W = $clog2(N), MAG_W = Q_IN+2, PAIRS = N/2
//   - an abs-saturate function
//  Sub-module fft_bin_mag: combinational (re, im) -> mag, instantiated twice, once per complex input.
//  Buffer: N x MAG_W register array, with 2 write ports (k and k+N/2) and 1 read port.
// TESTING (N=8, Q_IN=15)
//  1. Pairs k=0..3 in order, bins X[i] = (i*100, -i*10), ready_in=1 -> 8 beats (5 half-spectrum),
//     mag = i*110, bin_out = 0..7, last_out on the final beat only.
//  2. Pairs sent in order 3,1,0,2 -> output stays in natural bin order with magnitudes matching
//     test 1.
//  3. Re = -32768, Im = -32768 -> mag_out = 65534. Re = 0, Im = 0 -> mag_out = 0.
//  4. ready_in toggles 1,0,0,1,... -> no bin skipped or duplicated; outputs stay stable while stalled.
//  5. k=2 sent twice with different data, then k=0,1,3 -> second write wins; valid_out waits for k=3.
//     Then addr_in=5 -> addr_err=1 and the frame is unaffected.
//  6. valid_in during DRAIN -> overflow=1, drained data unchanged. reset low mid-COLLECT after
//     2 pairs -> outputs 0, and the next frame needs all 4 pairs.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types, default sizing and the saturating abs helper for the FFT bin collector.
package fft_pkg;

    typedef enum logic {COLLECT, DRAIN} fft_state_e;

    localparam int unsigned FFT_Q_IN   = 15;
    localparam int unsigned FFT_N      = 8;
    localparam int unsigned FFT_ADDR_W = 4;

    localparam int unsigned BIN_W = $clog2(FFT_N);
    localparam int unsigned MAG_W = FFT_Q_IN + 2;
    localparam int unsigned PAIRS = FFT_N / 2;

    // x is a sign-extended (q+1)-bit sample; the most negative value saturates to 2**q-1.
    function automatic logic [31:0] abs_sat(input logic signed [31:0] x, input int unsigned q);
        logic signed [31:0] min_v;
        min_v = -(32'sd1 <<< q);
        if (x == min_v) begin
            return (32'd1 << q) - 32'd1;
        end else if (x < 0) begin
            return unsigned'(-x);
        end else begin
            return unsigned'(x);
        end
    endfunction

endpackage

// File: rtl/fft_bin_mag.sv
// Combinational L1 magnitude |re|+|im| of one complex bin, with saturating abs.
module fft_bin_mag
    import fft_pkg::*;
#(
    parameter int unsigned Q_IN = FFT_Q_IN
) (
    input  logic signed [Q_IN:0]   re_i,
    input  logic signed [Q_IN:0]   im_i,
    output logic        [Q_IN+1:0] mag_o
);

    localparam int unsigned MagW = Q_IN + 2;

    logic [31:0] re_abs;
    logic [31:0] im_abs;
    logic        unused_abs_hi;

    always_comb begin
        re_abs = abs_sat(32'(re_i), Q_IN);
        im_abs = abs_sat(32'(im_i), Q_IN);
        mag_o  = MagW'(re_abs[Q_IN:0]) + MagW'(im_abs[Q_IN:0]);
    end

    assign unused_abs_hi = ^{re_abs[31:Q_IN+1], im_abs[31:Q_IN+1]};

endmodule

// File: rtl/fft_bin_collector.sv
// Collects FFT pair beats into a natural-order magnitude buffer and streams a full frame out.
// Build option: FFT_BIN_HALF_SPECTRUM_EN streams only bins 0..N/2.
module fft_bin_collector
    import fft_pkg::*;
#(
    parameter int unsigned Q_IN   = FFT_Q_IN,
    parameter int unsigned N      = FFT_N,
    parameter int unsigned ADDR_W = FFT_ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_in,
    input  logic [ADDR_W-1:0]      addr_in,
    input  logic signed [Q_IN:0]   data_real_0,
    input  logic signed [Q_IN:0]   data_imag_0,
    input  logic signed [Q_IN:0]   data_real_1,
    input  logic signed [Q_IN:0]   data_imag_1,
    input  logic                   ready_in,
    output logic                   valid_out,
    output logic [$clog2(N)-1:0]   bin_out,
    output logic [Q_IN+1:0]        mag_out,
    output logic                   last_out,
    output logic                   overflow,
    output logic                   addr_err
);

    localparam int unsigned BinW  = $clog2(N);
    localparam int unsigned MagW  = Q_IN + 2;
    localparam int unsigned Pairs = N / 2;
    localparam int unsigned CntW  = $clog2(Pairs + 1);
`ifdef FFT_BIN_HALF_SPECTRUM_EN
    localparam int unsigned LastBin = Pairs;
`else
    localparam int unsigned LastBin = N - 1;
`endif

    fft_state_e        state_q, state_d;
    logic [Pairs-1:0]  written_q, written_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [MagW-1:0]   bin_buf_q [N];
    logic [MagW-1:0]   bin_buf_d [N];
    logic              valid_out_q, valid_out_d;
    logic [BinW-1:0]   bin_q, bin_d;
    logic [MagW-1:0]   mag_q, mag_d;
    logic              last_q, last_d;
    logic              overflow_q, overflow_d;
    logic              addr_err_q, addr_err_d;

    logic [MagW-1:0]   mag_lo, mag_hi;
    logic [BinW-2:0]   k;
    logic              addr_ok;
    logic [BinW-1:0]   bin_next;

    fft_bin_mag #(.Q_IN(Q_IN)) u_mag_lo (
        .re_i  (data_real_0),
        .im_i  (data_imag_0),
        .mag_o (mag_lo)
    );

    fft_bin_mag #(.Q_IN(Q_IN)) u_mag_hi (
        .re_i  (data_real_1),
        .im_i  (data_imag_1),
        .mag_o (mag_hi)
    );

    assign k        = addr_in[BinW-2:0];
    assign addr_ok  = 32'(addr_in) < Pairs;
    assign bin_next = bin_q + BinW'(1);

    always_comb begin
        state_d     = state_q;
        written_d   = written_q;
        count_d     = count_q;
        bin_buf_d   = bin_buf_q;
        valid_out_d = valid_out_q;
        bin_d       = bin_q;
        mag_d       = mag_q;
        last_d      = last_q;
        overflow_d  = overflow_q;
        addr_err_d  = addr_err_q;

        unique case (state_q)
            COLLECT: begin
                if (valid_in) begin
                    if (!addr_ok) begin
                        addr_err_d = 1'b1;
                    end else begin
                        bin_buf_d[{1'b0, k}] = mag_lo;
                        bin_buf_d[{1'b1, k}] = mag_hi;
                        if (!written_q[k]) begin
                            written_d[k] = 1'b1;
                            count_d      = count_q + CntW'(1);
                        end
                    end
                end
                // Bin 0 is loaded from the post-write buffer so the completing beat is visible.
                if (count_d == CntW'(Pairs)) begin
                    state_d     = DRAIN;
                    valid_out_d = 1'b1;
                    bin_d       = '0;
                    mag_d       = bin_buf_d[0];
                    last_d      = 1'b0;
                end
            end
            DRAIN: begin
                if (valid_in) begin
                    overflow_d = 1'b1;
                end
                if (valid_out_q && ready_in) begin
                    if (last_q) begin
                        state_d     = COLLECT;
                        valid_out_d = 1'b0;
                        last_d      = 1'b0;
                        bin_d       = '0;
                        mag_d       = '0;
                        written_d   = '0;
                        count_d     = '0;
                    end else begin
                        bin_d  = bin_next;
                        mag_d  = bin_buf_q[bin_next];
                        last_d = (bin_next == BinW'(LastBin));
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= COLLECT;
            written_q   <= '0;
            count_q     <= '0;
            valid_out_q <= 1'b0;
            bin_q       <= '0;
            mag_q       <= '0;
            last_q      <= 1'b0;
            overflow_q  <= 1'b0;
            addr_err_q  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                bin_buf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            written_q   <= written_d;
            count_q     <= count_d;
            valid_out_q <= valid_out_d;
            bin_q       <= bin_d;
            mag_q       <= mag_d;
            last_q      <= last_d;
            overflow_q  <= overflow_d;
            addr_err_q  <= addr_err_d;
            bin_buf_q   <= bin_buf_d;
        end
    end

    assign valid_out = valid_out_q;
    assign bin_out   = bin_q;
    assign mag_out   = mag_q;
    assign last_out  = last_q;
    assign overflow  = overflow_q;
    assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_fft_bin_collector.sv
// Self-checking bench for fft_bin_collector: frame-level model plus directed literal checks.
module tb_fft_bin_collector;
    import fft_pkg::*;

`ifdef FFT_BIN_HALF_SPECTRUM_EN
    localparam int NB = FFT_N / 2 + 1;
`else
    localparam int NB = FFT_N;
`endif

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic                     valid_in = 1'b0;
    logic [FFT_ADDR_W-1:0]    addr_in = '0;
    logic signed [FFT_Q_IN:0] data_real_0 = '0;
    logic signed [FFT_Q_IN:0] data_imag_0 = '0;
    logic signed [FFT_Q_IN:0] data_real_1 = '0;
    logic signed [FFT_Q_IN:0] data_imag_1 = '0;
    logic                     ready_in = 1'b1;
    logic                     valid_out;
    logic [BIN_W-1:0]         bin_out;
    logic [MAG_W-1:0]         mag_out;
    logic                     last_out;
    logic                     overflow;
    logic                     addr_err;

    fft_bin_collector dut (
        .clk         (clk),
        .reset       (reset),
        .valid_in    (valid_in),
        .addr_in     (addr_in),
        .data_real_0 (data_real_0),
        .data_imag_0 (data_imag_0),
        .data_real_1 (data_real_1),
        .data_imag_1 (data_imag_1),
        .ready_in    (ready_in),
        .valid_out   (valid_out),
        .bin_out     (bin_out),
        .mag_out     (mag_out),
        .last_out    (last_out),
        .overflow    (overflow),
        .addr_err    (addr_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a bin array, a set of seen pairs, and a queue of beats still owed.
    typedef struct {int bin; int mag; bit last;} beat_t;
    beat_t exp_q[$];
    int    mbuf[FFT_N];
    bit    mseen[PAIRS];
    bit    mdrain = 0;
    bit    m_overflow = 0;
    bit    m_addr_err = 0;

    int cap_bin[$];
    int cap_mag[$];
    int cap_last[$];

    function automatic int l1(input int re, input int im);
        int a;
        int b;
        a = (re < 0) ? -re : re;
        b = (im < 0) ? -im : im;
        if (a > 32767) a = 32767;
        if (b > 32767) b = 32767;
        return a + b;
    endfunction

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            mdrain = 0;
            exp_q.delete();
            foreach (mseen[i]) mseen[i] = 0;
            m_overflow = 0;
            m_addr_err = 0;
        end else if (mdrain) begin
            if (valid_in) m_overflow = 1;
            if (ready_in && exp_q.size() > 0) begin
                beat_t b;
                b = exp_q.pop_front();
                if (b.last) begin
                    mdrain = 0;
                    foreach (mseen[i]) mseen[i] = 0;
                end
            end
        end else if (valid_in) begin
            int kk;
            int seen;
            kk = int'(addr_in);
            if (kk >= PAIRS) begin
                m_addr_err = 1;
            end else begin
                mbuf[kk]         = l1(int'(data_real_0), int'(data_imag_0));
                mbuf[kk + PAIRS] = l1(int'(data_real_1), int'(data_imag_1));
                mseen[kk] = 1;
                seen = 0;
                foreach (mseen[i]) seen += int'(mseen[i]);
                if (seen == PAIRS) begin
                    mdrain = 1;
                    for (int b = 0; b < NB; b++) begin
                        beat_t e;
                        e.bin  = b;
                        e.mag  = mbuf[b];
                        e.last = (b == NB - 1);
                        exp_q.push_back(e);
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (reset) begin
            check("valid_out", int'(valid_out), int'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                check("bin_out", int'(bin_out), exp_q[0].bin);
                check("mag_out", int'(mag_out), exp_q[0].mag);
                check("last_out", int'(last_out), int'(exp_q[0].last));
            end
            check("overflow", int'(overflow), int'(m_overflow));
            check("addr_err", int'(addr_err), int'(m_addr_err));
            if (valid_out && ready_in) begin
                cap_bin.push_back(int'(bin_out));
                cap_mag.push_back(int'(mag_out));
                cap_last.push_back(int'(last_out));
            end
        end
    end

    task automatic send_pair(input int kk, input int r0, input int i0, input int r1,
                             input int i1);
        @(posedge clk); #1;
        valid_in    = 1'b1;
        addr_in     = FFT_ADDR_W'(kk);
        data_real_0 = 16'(r0);
        data_imag_0 = 16'(i0);
        data_real_1 = 16'(r1);
        data_imag_1 = 16'(i1);
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic send_std(input int kk);
        send_pair(kk, kk * 100, -kk * 10, (kk + 4) * 100, -(kk + 4) * 10);
    endtask

    // mode 0: ready always high; mode 1: ready 1,0,0 repeating. inject>=0 drives one input beat.
    task automatic drain(input int mode, input int inject);
        int cyc;
        cyc = 0;
        cap_bin.delete();
        cap_mag.delete();
        cap_last.delete();
        while (mdrain && cyc < 200) begin
            @(posedge clk); #1;
            ready_in = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            valid_in = (cyc == inject);
            if (cyc == inject) begin
                addr_in     = FFT_ADDR_W'(1);
                data_real_0 = 16'sh1234;
                data_imag_0 = 16'sh0777;
                data_real_1 = -16'sh1234;
                data_imag_1 = 16'sh0100;
            end
            cyc++;
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        check("drain_done", int'(mdrain), 0);
    endtask

    task automatic check_std_caps(input string tag);
        check({tag, "_beats"}, cap_bin.size(), NB);
        for (int i = 0; i < NB && i < cap_bin.size(); i++) begin
            check({tag, "_bin"}, cap_bin[i], i);
            check({tag, "_mag"}, cap_mag[i], i * 110);
            check({tag, "_last"}, cap_last[i], int'(i == NB - 1));
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, int'(valid_out), 0);
        check({tag, "_bin"}, int'(bin_out), 0);
        check({tag, "_mag"}, int'(mag_out), 0);
        check({tag, "_last"}, int'(last_out), 0);
        check({tag, "_ovf"}, int'(overflow), 0);
        check({tag, "_aerr"}, int'(addr_err), 0);
    endtask

    initial begin
        #3;
        check_zero_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b1;

        // Pairs in order, free-flowing ready.
        for (int kk = 0; kk < 4; kk++) send_std(kk);
        drain(0, -1);
        check_std_caps("in_order");

        // Out-of-order pairs still drain in natural bin order.
        send_std(3); send_std(1); send_std(0); send_std(2);
        drain(0, -1);
        check_std_caps("shuffled");

        // Saturating abs and zero magnitude.
        send_pair(0, -32768, -32768, 0, 0);
        send_std(1); send_std(2); send_std(3);
        drain(0, -1);
        check("sat_mag", cap_mag[0], 65534);
        check("zero_mag", cap_mag[4], 0);

        // Stalling downstream.
        for (int kk = 0; kk < 4; kk++) send_std(kk);
        drain(1, -1);
        check_std_caps("stalled");

        // Duplicate pair: last write wins, no early drain.
        send_pair(2, 1, 2, 3, 4);
        send_pair(2, 7, 7, 1, -1);
        send_std(0); send_std(1);
        repeat (3) @(negedge clk);
        check("no_early_valid", int'(valid_out), 0);
        send_std(3);
        drain(0, -1);
        check("dup_mag2", cap_mag[2], 14);
        if (NB == FFT_N) check("dup_mag6", cap_mag[6], 2);

        // Out-of-range pair index mid-frame.
        send_std(0); send_std(1);
        send_pair(5, 999, 999, 999, 999);
        @(negedge clk);
        check("addr_err_set", int'(addr_err), 1);
        send_std(2); send_std(3);
        drain(0, -1);
        check_std_caps("after_addr_err");

        // Input beat during drain is dropped.
        for (int kk = 0; kk < 4; kk++) send_std(kk);
        drain(1, 2);
        check("overflow_set", int'(overflow), 1);
        check_std_caps("overflow");

        // Reset mid-collect discards the partial frame.
        send_std(0); send_std(1);
        @(posedge clk); #1;
        reset = 1'b0;
        #2;
        check_zero_outputs("midreset");
        @(posedge clk); #1;
        reset = 1'b1;
        send_std(2); send_std(3);
        repeat (3) @(negedge clk);
        check("partial_no_valid", int'(valid_out), 0);
        send_std(0); send_std(1);
        drain(0, -1);
        check_std_caps("post_reset");

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
